shift_reg_serial_tx: RTL



---
 rtl/shift_reg_serial_tx_if.sv | 32 +++
 rtl/shift_reg_serial_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_serial_tx_if.sv
// Purpose : word handshake and serial-line bundle between a parallel source and shift_reg_serial_tx.
// Latency : none; this is a plain signal bundle.
// Backpr. : load_ready is driven by the transmitter; the source holds data_par/load_valid until accepted.
// Ports   : data_par, load_valid (source -> tx); load_ready, tx_out, busy, done (tx -> consumer).
interface shift_reg_serial_tx_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] data_par;
  logic              load_valid;
  logic              load_ready;
  logic              tx_out;
  logic              busy;
  logic              done;

  modport master (
    output data_par,
    output load_valid,
    input  load_ready,
    input  tx_out,
    input  busy,
    input  done
  );

  modport slave (
    input  data_par,
    input  load_valid,
    output load_ready,
    output tx_out,
    output busy,
    output done
  );
endinterface

// File: rtl/shift_reg_serial_tx.sv
// Purpose : serialises a 4-bit word as start, 4 data bits LSB first, [parity], stop; BAUD_DIV cycles per bit.
// Latency : start bit on the line the cycle after the accept edge; done pulses 6*BAUD_DIV (7 with parity) cycles after accept.
// Backpr. : load_ready is high only in IDLE (including the done cycle); load_valid while busy is ignored.
// Ports   : CLK clock, Clear async active-low reset, bus (slave modport): data_par, load_valid, load_ready, tx_out, busy, done.
// Option  : define TX_PARITY_EN to insert a parity bit after the data bits (PARITY_ODD selects odd sense).
module shift_reg_serial_tx #(
  parameter int DATA_W     = 4,
  parameter int BAUD_DIV   = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                  CLK,
  input  logic                  Clear,
  shift_reg_serial_tx_if.slave  bus
);

  localparam logic [7:0] BAUD_LAST = 8'(BAUD_DIV - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_W - 1);

  if (DATA_W != 4) begin : g_bad_data_w
    $error("shift_reg_serial_tx: DATA_W must be 4");
  end
  if (BAUD_DIV < 1 || BAUD_DIV > 255) begin : g_bad_baud
    $error("shift_reg_serial_tx: BAUD_DIV must be in 1..255");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("shift_reg_serial_tx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            r_state;
  logic [7:0]        r_baud_cnt;
  logic [2:0]        r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;

  state_t            w_state_nxt;
  logic [7:0]        w_baud_nxt;
  logic [2:0]        w_bit_nxt;
  logic [DATA_W-1:0] w_shift_nxt;
  logic              w_tx_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_baud_last;

`ifdef TX_PARITY_EN
  // Parity is fixed at accept time so later data_par changes cannot disturb it.
  logic r_par;
  logic w_par_nxt;
`endif

  assign w_baud_last = (r_baud_cnt == BAUD_LAST);

  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= 8'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
`ifdef TX_PARITY_EN
      r_par      <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
`ifdef TX_PARITY_EN
    w_par_nxt   = r_par;
`endif

    // Every bit state shares the same baud timer: count to BAUD_LAST, then restart.
    if (r_state != S_IDLE) begin
      w_baud_nxt = w_baud_last ? 8'd0 : r_baud_cnt + 8'd1;
    end

    case (r_state)
      S_IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        w_baud_nxt = 8'd0;
        w_bit_nxt  = 3'd0;
        if (bus.load_valid) begin
          w_state_nxt = S_START;
          w_shift_nxt = bus.data_par;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
`ifdef TX_PARITY_EN
          w_par_nxt   = (^bus.data_par) ^ 1'(PARITY_ODD);
`endif
        end
      end

      S_START: begin
        if (w_baud_last) begin
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
        end
      end

      S_DATA: begin
        if (w_baud_last) begin
          w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_nxt = 3'd0;
`ifdef TX_PARITY_EN
            w_state_nxt = S_PARITY;
            w_tx_nxt    = r_par;
`else
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_bit_nxt = r_bit_cnt + 3'd1;
            // Next line value is the bit about to become the LSB.
            w_tx_nxt  = r_shift[1];
          end
        end
      end

`ifdef TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_last) begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (w_baud_last) begin
          w_state_nxt = S_IDLE;
          w_tx_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Ready is decoded from state so a word can be taken in the done cycle.
  assign bus.load_ready = (r_state == S_IDLE);
  assign bus.tx_out     = r_tx;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule
